req_pulse_responder: RTL and testbench

Responder end of the single-cycle request-pulse protocol (req must be high for exactly one cycle, `req |=> !req`). It accepts request pulses, returns a one-cycle `ack` a fixed number of cycles later, and bounds the number of outstanding requests. It detects and counts protocol violations and overflows, and sits directly opposite any requester that drives the pulse-style `req` line.

---
 rtl/req_pulse_responder.sv | 102 ++++++++++
 tb/tb_req_pulse_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/req_pulse_responder.sv
// Responder for the single-cycle request-pulse protocol: fixed-latency ack, bounded in-flight count,
// violation/overflow tracking. Define REQ_PULSE_RSP_SVA_EN to compile in embedded assertions and covers.
module req_pulse_responder #(
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 8,
    localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             clr_err,
    output logic             ack,
    output logic             busy,
    output logic [OW-1:0]    outstanding,
    output logic             overflow,
    output logic             viol,
    output logic [CNT_W-1:0] viol_cnt
);

    typedef enum logic [1:0] {IDLE, ACTIVE, HALT} state_t;

    state_t             state, state_next;
    logic               req_q;
    logic [LATENCY-1:0] pipe, pipe_next;
    logic               new_req, accept, drop;
    logic [OW-1:0]      after_ack, out_next;
    logic               ovf_next;
    logic [CNT_W-1:0]   cnt_next;

    // A held req is a violation, never a new request
    assign new_req = req & ~req_q;
    assign viol    = req & req_q;
    assign ack     = pipe[LATENCY-1];
    assign busy    = (outstanding != '0);

    always_comb begin
        after_ack  = outstanding - OW'(ack);
        accept     = 1'b0;
        drop       = 1'b0;
        if (new_req && state != HALT) begin
            if (after_ack < OW'(MAX_OUTSTANDING))
                accept = 1'b1;
            else
                drop = 1'b1;
        end
        out_next  = after_ack + OW'(accept);
        pipe_next = (pipe << 1) | LATENCY'(accept);

        ovf_next = overflow | drop;
        cnt_next = viol_cnt;
        if (viol && viol_cnt != {CNT_W{1'b1}})
            cnt_next = viol_cnt + 1'b1;

        state_next = state;
        if (clr_err) begin
            // Clear wins over a same-cycle drop, so the responder never stays halted
            ovf_next   = 1'b0;
            cnt_next   = '0;
            state_next = (out_next != '0) ? ACTIVE : IDLE;
        end else if (state == HALT) begin
            state_next = HALT;
        end else if (drop) begin
            state_next = HALT;
        end else begin
            state_next = (out_next != '0) ? ACTIVE : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            pipe        <= '0;
            outstanding <= '0;
            overflow    <= 1'b0;
            viol_cnt    <= '0;
        end else begin
            state       <= state_next;
            req_q       <= req;
            pipe        <= pipe_next;
            outstanding <= out_next;
            overflow    <= ovf_next;
            viol_cnt    <= cnt_next;
        end
    end

`ifdef REQ_PULSE_RSP_SVA_EN
    a_req_pulse: assert property (@(posedge clk) disable iff (rst) req |=> !req)
        else $error("req_pulse_responder: req held high for more than one cycle");
    a_ack_src: assert property (@(posedge clk) disable iff (rst) ack |-> $past(accept, LATENCY))
        else $error("req_pulse_responder: ack without an accepted request LATENCY cycles earlier");
    a_out_max: assert property (@(posedge clk) disable iff (rst) outstanding <= OW'(MAX_OUTSTANDING))
        else $error("req_pulse_responder: outstanding exceeds MAX_OUTSTANDING");
    a_ovf_sticky: assert property (@(posedge clk) disable iff (rst) overflow && !clr_err |=> overflow)
        else $error("req_pulse_responder: overflow dropped without clr_err");
    c_overflow:  cover property (@(posedge clk) disable iff (rst) drop);
    c_halt_exit: cover property (@(posedge clk) disable iff (rst) state == HALT ##1 state != HALT);
    c_cnt_sat:   cover property (@(posedge clk) disable iff (rst) viol && viol_cnt == {CNT_W{1'b1}});
`endif

endmodule

// File: tb/tb_req_pulse_responder.sv
// Randomised and directed bench for req_pulse_responder against a due-time queue reference model.
module tb_req_pulse_responder;

    localparam int LAT  = 5;
    localparam int MAXO = 2;
    localparam int CW   = 3;
    localparam int OW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          clr_err;
    logic          ack;
    logic          busy;
    logic [OW-1:0] outstanding;
    logic          overflow;
    logic          viol;
    logic [CW-1:0] viol_cnt;

    req_pulse_responder #(.LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .clr_err(clr_err), .ack(ack), .busy(busy),
        .outstanding(outstanding), .overflow(overflow), .viol(viol), .viol_cnt(viol_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycle numbers at which each accepted request is due to ack
    int due[$];
    int cyc;
    bit m_prev, m_ovf, m_halt;
    int m_vcnt;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (model cycle %0d, time %0t)", tag, obs, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        due.delete();
        m_prev = 1'b0;
        m_ovf  = 1'b0;
        m_halt = 1'b0;
        m_vcnt = 0;
    endtask

    // One clock cycle: entered just after a rising edge, leaves just after the next one
    task automatic step(input bit r, input bit c);
        bit ack_now, newr, acc, drp;
        int after;
        req     = r;
        clr_err = c;
        @(negedge clk);
        ack_now = (due.size() > 0) && (due[0] == cyc);
        check("ack", ack, ack_now);
        check("outstanding", outstanding, due.size());
        check("busy", busy, due.size() != 0);
        check("overflow", overflow, m_ovf);
        check("viol", viol, r && m_prev);
        check("viol_cnt", viol_cnt, m_vcnt);

        newr  = r && !m_prev;
        after = due.size() - (ack_now ? 1 : 0);
        acc   = newr && !m_halt && (after < MAXO);
        drp   = newr && !m_halt && !acc;
        if (ack_now) void'(due.pop_front());
        if (acc) due.push_back(cyc + LAT);
        if (r && m_prev && m_vcnt < (1 << CW) - 1) m_vcnt++;
        if (drp) begin
            m_ovf  = 1'b1;
            m_halt = 1'b1;
        end
        if (c) begin
            m_ovf  = 1'b0;
            m_vcnt = 0;
            m_halt = 1'b0;
        end
        m_prev = r;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = 1'b0;
        clr_err = 1'b0;
        rst     = 1'b1;
        #1;
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_overflow", overflow, 0);
        check("rst_viol", viol, 0);
        check("rst_viol_cnt", viol_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc++;
    endtask

    initial begin
        bit r;
        bit c;
        rst     = 1'b1;
        req     = 1'b0;
        clr_err = 1'b0;
        cyc     = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        repeat (3) step(0, 0);
        // single pulse
        step(1, 0);
        repeat (8) step(0, 0);
        // pulses every other cycle
        repeat (5) begin
            step(1, 0);
            step(0, 0);
        end
        repeat (8) step(0, 0);
        // overflow: third pulse inside the latency window is dropped, later pulse ignored
        step(1, 0); step(0, 0); step(1, 0); step(0, 0); step(1, 0);
        repeat (3) step(0, 0);
        step(1, 0);
        repeat (4) step(0, 0);
        step(0, 1);
        repeat (3) step(0, 0);
        step(1, 0);
        repeat (7) step(0, 0);
        // long hold saturates the violation counter
        repeat (10) step(1, 0);
        step(0, 0);
        step(0, 1);
        // clear in the same cycle as a violation
        step(1, 0); step(1, 0); step(1, 1); step(0, 0);
        repeat (6) step(0, 0);
        // reset with a request in flight
        step(1, 0); step(0, 0); step(0, 0);
        do_reset();
        repeat (8) step(0, 0);

        r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (r) r = ($urandom_range(3) == 0);
            else   r = ($urandom_range(2) == 0);
            c = ($urandom_range(39) == 0);
            if ($urandom_range(299) == 0) begin
                do_reset();
                r = 1'b0;
            end else begin
                step(r, c);
            end
        end
        step(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
